nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 18 +
 rtl/nibble_serial_adder_ctrl_rca.sv | 22 ++
 rtl/nibble_serial_adder_ctrl.sv | 123 ++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
// Holds the FSM state encoding, the nibble width and the pass-count helper.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of nibble passes needed for a given operand width.
    function automatic int nibbles(input int width);
        return width / NIBBLE;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_rca.sv
// 4-bit ripple-carry adder shared by the nibble-serial sequencer.
// Ports: A, B (4-bit addends), Cin (carry in), Sum (4-bit), Cout (carry out).
module ripple_carry_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [4:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign Sum[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-precision add/subtract sequencer: one 4-bit adder, one nibble per cycle.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, sub;
//        out_valid/out_ready with sum, cout, ovf; busy high while in RUN.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N     = nibbles(WIDTH);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int MSB   = WIDTH - 1;

    if ((WIDTH % NIBBLE) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   nib_idx_q, nib_idx_d;

    logic [NIBBLE-1:0]  rca_a, rca_b, rca_sum;
    logic               rca_cout;
    logic               accept;
    logic               last_nib;

    assign rca_a = a_q[NIBBLE*nib_idx_q +: NIBBLE];
    assign rca_b = b_q[NIBBLE*nib_idx_q +: NIBBLE];

    ripple_carry_adder u_rca (
        .A    (rca_a),
        .B    (rca_b),
        .Cin  (carry_q),
        .Sum  (rca_sum),
        .Cout (rca_cout)
    );

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign last_nib  = (nib_idx_q == IDX_W'(N - 1));
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign sum       = sum_q;
    assign cout      = out_valid && carry_q;
    // B is stored already inverted for subtract, so one rule covers both ops.
    assign ovf       = out_valid && (a_q[MSB] == b_q[MSB]) &&
                       (sum_q[MSB] != a_q[MSB]);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        nib_idx_d = nib_idx_q;

        unique case (state_q)
            RUN: begin
                sum_d[NIBBLE*nib_idx_q +: NIBBLE] = rca_sum;
                carry_d = rca_cout;
                if (last_nib) begin
                    state_d = DONE;
                end else begin
                    nib_idx_d = nib_idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready && !in_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept covers both IDLE and the back-to-back path out of DONE.
        if (accept) begin
            state_d   = RUN;
            a_d       = a;
            b_d       = sub ? ~b : b;
            carry_d   = sub;
            sum_d     = '0;
            nib_idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            nib_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            nib_idx_q <= nib_idx_d;
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
// Directed cases plus randomized operands against an arithmetic model.
module tb_nibble_serial_adder_ctrl;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic, no nibble view.
    function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic s);
        int sx, sy, r, ux, uy;
        logic [W-1:0] rs;
        logic c, o;
        sx = int'($signed(x));
        sy = int'($signed(y));
        ux = int'(x);
        uy = int'(y);
        r  = s ? sx - sy : sx + sy;
        o  = (r > 32767) || (r < -32768);
        c  = s ? (ux >= uy) : (ux + uy > 65535);
        rs = s ? x - y : x + y;
        return {o, c, rs};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE, wait for the result, check latency and value.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, input string tag);
        logic [W+1:0] e;
        int lat;
        e = model(x, y, s);
        a = x; b = y; sub = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"},  lat,  N);
        chk({tag, "_sum"},  sum,  e[W-1:0]);
        chk({tag, "_cout"}, cout, e[W]);
        chk({tag, "_ovf"},  ovf,  e[W+1]);
        tick();
    endtask

    initial begin
        logic [W+1:0] e;
        int lat;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();

        run_op(16'h1234, 16'h0FFF, 1'b0, "add");
        run_op(16'hFFFF, 16'h0001, 1'b0, "ripple");
        run_op(16'h7FFF, 16'h0001, 1'b0, "sovf");
        run_op(16'h0005, 16'h0007, 1'b1, "borrow");
        run_op(16'h8000, 16'h0001, 1'b1, "subovf");

        // Backpressure then back-to-back accept from DONE.
        out_ready = 1'b0;
        e = model(16'hABCD, 16'h1357, 1'b1);
        a = 16'hABCD; b = 16'h1357; sub = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_busy", busy, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_lat", lat, N);
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom;
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", sum, e[W-1:0]);
            chk("bp_cout", cout, e[W]);
            chk("bp_ovf", ovf, e[W+1]);
            tick();
        end
        out_ready = 1'b1;
        a = 16'h0001; b = 16'h0001; sub = 1'b0; in_valid = 1'b1;
        #1;
        chk("b2b_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_valid", out_valid, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("b2b_lat", lat, N);
        chk("b2b_sum", sum, 16'h0002);
        chk("b2b_cout", cout, 0);
        tick();

        // Reset during the second RUN cycle of a carry-heavy subtract.
        a = 16'hFFFF; b = 16'h0000; sub = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_in_ready", in_ready, 1);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_busy_clr", busy, 0);
        chk("mid_sum", sum, 0);
        run_op(16'h0100, 16'h0100, 1'b0, "post_rst");

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] rx, ry;
            rx = W'($urandom);
            ry = W'($urandom);
            if (i % 8 == 0) ry = rx;
            run_op(rx, ry, 1'(($urandom >> 3) & 1), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
